// File: rtl/lab2_serial_word_tx.sv
// Serial word transmitter: shifts a 4-bit word MSB-first on X, one bit per SCLK.
// Optional macro LAB2_TX_PARITY_EN appends an even-parity bit (5-bit frame).
module lab2_serial_word_tx #(
    parameter int DIV_HALF = 50_000_000
) (
    input  logic       clk100Mhz,
    input  logic       CLR,
    input  logic [3:0] D,
    input  logic       START,
    output logic       READY,
    output logic       SCLK,
    output logic       X,
    output logic       FRAME,
    output logic       DONE
);

    localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_HALF - 1);

`ifdef LAB2_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, ARM, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;
`endif

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic [3:0]    r_sh;
    logic [3:0]    w_sh_nxt;
    logic [1:0]    r_bitcnt;
    logic [1:0]    w_bitcnt_nxt;
    logic          r_x;
    logic          w_x_nxt;
    logic          r_frame;
    logic          w_frame_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_tick;
    logic          w_rise;
`ifdef LAB2_TX_PARITY_EN
    logic          r_par;
    logic          w_par_nxt;
`endif

    assign w_tick = (r_cnt == CNT_MAX);
    assign w_rise = w_tick & ~r_sclk;

    assign READY = (r_state == IDLE);
    assign SCLK  = r_sclk;
    assign X     = r_x;
    assign FRAME = r_frame;
    assign DONE  = r_done;

    // Free-running SCLK divider; never restarted by START.
    always_ff @(posedge clk100Mhz or negedge CLR) begin
        if (!CLR) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk100Mhz or negedge CLR) begin
        if (!CLR) begin
            r_state  <= IDLE;
            r_sh     <= '0;
            r_bitcnt <= '0;
            r_x      <= 1'b0;
            r_frame  <= 1'b0;
            r_done   <= 1'b0;
`ifdef LAB2_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_sh     <= w_sh_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_x      <= w_x_nxt;
            r_frame  <= w_frame_nxt;
            r_done   <= w_done_nxt;
`ifdef LAB2_TX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    // Next-state logic: bits change only on SCLK rise events.
    always_comb begin
        w_state_nxt  = r_state;
        w_sh_nxt     = r_sh;
        w_bitcnt_nxt = r_bitcnt;
        w_x_nxt      = r_x;
        w_frame_nxt  = r_frame;
        w_done_nxt   = 1'b0;
`ifdef LAB2_TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_sh_nxt     = D;
                    w_bitcnt_nxt = 2'd0;
`ifdef LAB2_TX_PARITY_EN
                    w_par_nxt    = ^D;
`endif
                    w_state_nxt  = ARM;
                end
            end
            ARM: begin
                if (w_rise) begin
                    w_x_nxt     = r_sh[3];
                    w_sh_nxt    = {r_sh[2:0], 1'b0};
                    w_frame_nxt = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    w_frame_nxt = 1'b0;
                    if (r_bitcnt != 2'd3) begin
                        w_x_nxt      = r_sh[3];
                        w_sh_nxt     = {r_sh[2:0], 1'b0};
                        w_bitcnt_nxt = r_bitcnt + 2'd1;
                    end else begin
`ifdef LAB2_TX_PARITY_EN
                        w_x_nxt     = r_par;
                        w_state_nxt = PAR;
`else
                        w_x_nxt     = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
`endif
                    end
                end
            end
`ifdef LAB2_TX_PARITY_EN
            PAR: begin
                if (w_rise) begin
                    w_x_nxt     = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lab2_serial_word_tx.sv
// Bench for lab2_serial_word_tx with DIV_HALF=2 (SCLK period 4 cycles).
// Words are queued when START is driven and checked bit by bit on SCLK rises.
module tb_lab2_serial_word_tx;

    localparam int DH  = 2;
    localparam int PER = 2 * DH;
`ifdef LAB2_TX_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic       clk100Mhz = 1'b0;
    logic       CLR = 1'b0;
    logic [3:0] D = 4'b0;
    logic       START = 1'b0;
    logic       READY, SCLK, X, FRAME, DONE;

    int checks = 0;
    int errors = 0;

    logic [3:0] sb[$];

    bit         mon_en = 1'b0;
    logic       prev_sclk = 1'b0;
    logic       prev_x = 1'b0;
    logic       m_rise;
    bit         in_frame = 1'b0;
    int         bit_idx = 0;
    logic [3:0] cur = 4'b0;
    int         cyc = 0;
    bit         per_valid = 1'b0;
    int         rsd = 0;
    bit         chk_gap = 1'b0;
    int         done_cnt = 0;

    lab2_serial_word_tx #(.DIV_HALF(DH)) dut (
        .clk100Mhz(clk100Mhz),
        .CLR      (CLR),
        .D        (D),
        .START    (START),
        .READY    (READY),
        .SCLK     (SCLK),
        .X        (X),
        .FRAME    (FRAME),
        .DONE     (DONE)
    );

    always #5 clk100Mhz = ~clk100Mhz;

    initial begin
        #200000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    function automatic logic exp_bit(input logic [3:0] w, input int i);
        if (i < 4) return w[3-i];
        return ^w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples at negedge, checks every bit against the queued word.
    always @(negedge clk100Mhz) begin
        if (mon_en) begin
            m_rise = SCLK && !prev_sclk;
            cyc++;
            if (!m_rise) begin
                chk("x_stable", X, prev_x);
                chk("done_quiet", DONE, 1'b0);
            end else begin
                if (per_valid) chk("sclk_period", cyc, PER);
                cyc = 0;
                per_valid = 1'b1;
                if (in_frame) begin
                    bit_idx++;
                    if (bit_idx < FLEN) begin
                        chk("bit", X, exp_bit(cur, bit_idx));
                        chk("frame_low", FRAME, 1'b0);
                        chk("done_mid", DONE, 1'b0);
                    end else begin
                        chk("end_x", X, 1'b0);
                        chk("done_end", DONE, 1'b1);
                        chk("frame_end", FRAME, 1'b0);
                        in_frame = 1'b0;
                        done_cnt++;
                        rsd = 0;
                    end
                end else if (FRAME === 1'b1) begin
                    chk("frame_expected", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) cur = sb.pop_front();
                    else cur = 4'b0;
                    if (chk_gap) chk("word_gap", rsd, 0);
                    in_frame = 1'b1;
                    bit_idx = 0;
                    chk("bit0", X, exp_bit(cur, 0));
                    chk("done_start", DONE, 1'b0);
                end else begin
                    chk("idle_x", X, 1'b0);
                    chk("idle_done", DONE, 1'b0);
                    rsd++;
                end
            end
            prev_sclk = SCLK;
            prev_x = X;
        end
    end

    task automatic step();
        @(negedge clk100Mhz);
        #1;
    endtask

    task automatic send(input logic [3:0] w);
        chk("ready_at_start", READY, 1'b1);
        D = w;
        START = 1'b1;
        sb.push_back(w);
        step();
        START = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (DONE !== 1'b1 && n < lim);
        chk("done_seen", DONE, 1'b1);
        chk("ready_with_done", READY, 1'b1);
    endtask

    task automatic wait_bit(input int idx, input int lim);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(in_frame && bit_idx == idx) && n < lim);
        chk("bit_reached", in_frame && bit_idx == idx, 1'b1);
    endtask

    initial begin
        // Reset values while CLR is held low.
        #1;
        chk("rst_sclk", SCLK, 1'b0);
        chk("rst_x", X, 1'b0);
        chk("rst_ready", READY, 1'b1);
        chk("rst_frame", FRAME, 1'b0);
        chk("rst_done", DONE, 1'b0);
        step();
        step();
        CLR = 1'b1;
        prev_sclk = 1'b0;
        prev_x = 1'b0;
        mon_en = 1'b1;
        step();

        // 1: single word 1101.
        send(4'b1101);
        wait_done(20 * PER);
        step();

        // 2: back-to-back words started in the DONE cycle.
        send(4'b1101);
        wait_done(20 * PER);
        chk_gap = 1'b1;
        send(4'b1100);
        wait_done(20 * PER);
        send(4'b1011);

        // 3: START while busy is ignored.
        wait_bit(1, 10 * PER);
        step();
        D = 4'b0000;
        START = 1'b1;
        chk("busy_ready", READY, 1'b0);
        step();
        START = 1'b0;
        chk("busy_ready2", READY, 1'b0);
        wait_done(20 * PER);
        chk_gap = 1'b0;
        repeat (3 * PER) step();
        chk("no_extra_frame", in_frame, 1'b0);
        chk("idle_ready", READY, 1'b1);

        // 4: asynchronous reset mid bit 1.
        send(4'b1010);
        wait_bit(1, 10 * PER);
        step();
        #2;
        mon_en = 1'b0;
        CLR = 1'b0;
        #1;
        chk("arst_x", X, 1'b0);
        chk("arst_sclk", SCLK, 1'b0);
        chk("arst_ready", READY, 1'b1);
        chk("arst_frame", FRAME, 1'b0);
        chk("arst_done", DONE, 1'b0);
        sb.delete();
        in_frame = 1'b0;
        per_valid = 1'b0;
        cyc = 0;
        rsd = 0;
        step();
        step();
        CLR = 1'b1;
        prev_sclk = 1'b0;
        prev_x = 1'b0;
        mon_en = 1'b1;
        step();
        send(4'b0110);
        wait_done(20 * PER);
        step();

        // 5: parity-relevant words (frame length follows the macro).
        send(4'b1011);
        wait_done(20 * PER);
        send(4'b1001);
        wait_done(20 * PER);
        step();

        // 6: START held high gives repeating frames.
        chk("hold_ready", READY, 1'b1);
        D = 4'b1100;
        START = 1'b1;
        sb.push_back(4'b1100);
        sb.push_back(4'b1100);
        sb.push_back(4'b1100);
        wait_done(20 * PER);
        chk_gap = 1'b1;
        wait_done(20 * PER);
        step();
        START = 1'b0;
        wait_done(20 * PER);
        chk_gap = 1'b0;
        repeat (3 * PER) step();

        chk("queue_empty", sb.size(), 0);
        chk("not_in_frame", in_frame, 1'b0);
        chk("done_count", done_cnt, 10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
